// File: rtl/key_event.sv
// Key-gesture classifier: turns debounced press/release pulses into short, long and double-click events.
// Optional auto-repeat while held is compiled in with `define KEY_EVENT_REPEAT_EN.
module key_event #(
  parameter int CNT_BITS      = 26,
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int DBL_CYCLES    = 12_500_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk50m,
  input  logic rst,
  input  logic sw_hi,
  input  logic sw_lo,
  output logic ev_short,
  output logic ev_long,
  output logic ev_double,
  output logic ev_repeat,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    HELD
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DBL_LAST  = CNT_BITS'(DBL_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_BITS-1:0] REP_LAST  = CNT_BITS'(REPEAT_CYCLES - 1);
`endif

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                press;
  logic                release_;

  // A simultaneous press and release is treated as no input at all.
  assign press    = sw_hi & ~sw_lo;
  assign release_ = sw_lo & ~sw_hi;
  assign busy     = (state != IDLE);

  // NOTE: every register here is written with <= so all next-state terms see the pre-edge values.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ev_short  <= 1'b0;
      ev_long   <= 1'b0;
      ev_double <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      ev_repeat <= 1'b0;
`endif
    end else begin
      ev_short  <= 1'b0;
      ev_long   <= 1'b0;
      ev_double <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      ev_repeat <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press) state <= PRESS1;
        end
        PRESS1: begin
          if (release_) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            ev_long <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT2: begin
          // A press on the very last gap cycle still counts as a double click.
          if (press) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == DBL_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            ev_short <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESS2: begin
          cnt <= '0;
          if (release_) begin
            state     <= IDLE;
            ev_double <= 1'b1;
          end
        end
        HELD: begin
          if (release_) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (cnt == REP_LAST) begin
              cnt       <= '0;
              ev_repeat <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
`else
            cnt <= '0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef KEY_EVENT_REPEAT_EN
  assign ev_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: stimulus pushes expected events with their cycle, a monitor pops and compares.
module tb_key_event;

  localparam int CNT_BITS = 4;
  localparam int LONG_C   = 8;
  localparam int DBL_C    = 5;
  localparam int REP_C    = 3;

  typedef enum int { K_SHORT, K_LONG, K_DOUBLE, K_REPEAT } kind_t;
  typedef struct { kind_t kind; int cyc; } exp_t;

  logic clk50m = 1'b0;
  logic rst    = 1'b1;
  logic sw_hi  = 1'b0;
  logic sw_lo  = 1'b0;
  logic ev_short, ev_long, ev_double, ev_repeat, busy;

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  key_event #(
    .CNT_BITS(CNT_BITS), .LONG_CYCLES(LONG_C), .DBL_CYCLES(DBL_C), .REPEAT_CYCLES(REP_C)
  ) dut (
    .clk50m(clk50m), .rst(rst), .sw_hi(sw_hi), .sw_lo(sw_lo),
    .ev_short(ev_short), .ev_long(ev_long), .ev_double(ev_double),
    .ev_repeat(ev_repeat), .busy(busy)
  );

  always #10 clk50m = ~clk50m;
  always @(posedge clk50m) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input kind_t k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Drives edges 0..n-1 from the given masks; optionally checks busy after each edge.
  task automatic play(input string name, input int n, input logic [31:0] hi_m,
                      input logic [31:0] lo_m, input logic [31:0] busy_m);
    for (int e = 0; e < n; e++) begin
      sw_hi = hi_m[e];
      sw_lo = lo_m[e];
      @(negedge clk50m);
      check({name, " busy"}, int'(busy), int'(busy_m[e]));
    end
    sw_hi = 1'b0;
    sw_lo = 1'b0;
  endtask

  // Monitor: every event pulse is matched against the head of the scoreboard.
  always @(negedge clk50m) begin
    if (!rst && (ev_short || ev_long || ev_double || ev_repeat)) begin
      kind_t k;
      exp_t  e;
      k = ev_short ? K_SHORT : ev_long ? K_LONG : ev_double ? K_DOUBLE : K_REPEAT;
      check("one-hot events", int'(ev_short) + int'(ev_long) + int'(ev_double) + int'(ev_repeat), 1);
      if (sb.size() == 0) begin
        check("unexpected event kind", int'(k), -1);
      end else begin
        e = sb.pop_front();
        check("event kind", int'(k), int'(e.kind));
        check("event cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int base;
    repeat (3) @(negedge clk50m);
    check("reset busy", int'(busy), 0);
    check("reset events", int'({ev_short, ev_long, ev_double, ev_repeat}), 0);
    rst = 1'b0;
    @(negedge clk50m);

    // Short press: hi@0, lo@3 -> ev_short after edge 8.
    base = cyc + 1;
    expect_ev(K_SHORT, base + 8);
    play("short", 12, 32'h1, 32'h8, 32'h0FF);

    // Long hold: ev_long after 8, repeats at 11/14/17 when enabled, release at 19 is silent.
    base = cyc + 1;
    expect_ev(K_LONG, base + 8);
`ifdef KEY_EVENT_REPEAT_EN
    expect_ev(K_REPEAT, base + 11);
    expect_ev(K_REPEAT, base + 14);
    expect_ev(K_REPEAT, base + 17);
`endif
    play("long", 24, 32'h1, 32'h1 << 19, 32'h7FFFF);

    // Double click with second press at gap cnt=3.
    base = cyc + 1;
    expect_ev(K_DOUBLE, base + 9);
    play("double", 16, 32'h41, 32'h204, 32'h1FF);

    // Double click with second press coinciding with the gap timeout (edge 7).
    base = cyc + 1;
    expect_ev(K_DOUBLE, base + 9);
    play("double edge", 16, 32'h81, 32'h204, 32'h1FF);

    // Release on edge 7: no long event, short after 12.
    base = cyc + 1;
    expect_ev(K_SHORT, base + 12);
    play("late release", 16, 32'h1, 32'h80, 32'hFFF);

    // Simultaneous hi+lo in IDLE is ignored.
    play("both idle", 6, 32'h1, 32'h1, 32'h0);

    // Simultaneous hi+lo at edge 3 in PRESS1 ignored; real release at 5 -> short at 10.
    base = cyc + 1;
    expect_ev(K_SHORT, base + 10);
    play("both press1", 14, 32'h9, 32'h28, 32'h3FF);

    // Illegal second press in PRESS1 ignored; release at 4 -> short at 9.
    base = cyc + 1;
    expect_ev(K_SHORT, base + 9);
    play("illegal hi", 12, 32'h5, 32'h10, 32'h1FF);

    // Reset mid-press aborts silently; the following release is ignored.
    play("pre-reset", 4, 32'h1, 32'h0, 32'hF);
    rst = 1'b1;
    #1;
    check("async reset busy", int'(busy), 0);
    check("async reset events", int'({ev_short, ev_long, ev_double, ev_repeat}), 0);
    repeat (2) @(negedge clk50m);
    rst = 1'b0;
    play("post-reset", 14, 32'h0, 32'h1, 32'h0);

    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
